// File: rtl/mbinit_sb_tx_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module   : mbinit_sb_tx_arbiter_if
// Purpose  : Request/launch/completion bundle between the MBINIT engines,
//            the sideband TX arbiter and the sideband transmitter.
// Revision : 1.0
// =====================================================================
interface mbinit_sb_tx_arbiter_if #(
  parameter int MSG_W  = 4,
  parameter int INFO_W = 3
);
  logic              i_en;
  logic              i_req_valid_init;
  logic [MSG_W-1:0]  i_req_msg_init;
  logic [INFO_W-1:0] i_req_info_init;
  logic              i_req_valid_partner;
  logic [MSG_W-1:0]  i_req_msg_partner;
  logic [INFO_W-1:0] i_req_info_partner;
  logic              i_sb_busy;
  logic              o_sb_valid;
  logic [MSG_W-1:0]  o_sb_msg;
  logic [INFO_W-1:0] o_sb_info;
  logic              o_src_id;
  logic              o_grant_init;
  logic              o_grant_partner;
  logic              o_done_init;
  logic              o_done_partner;
  logic              o_timeout;

  // Arbiter side
  modport slave (
    input  i_en,
    input  i_req_valid_init,
    input  i_req_msg_init,
    input  i_req_info_init,
    input  i_req_valid_partner,
    input  i_req_msg_partner,
    input  i_req_info_partner,
    input  i_sb_busy,
    output o_sb_valid,
    output o_sb_msg,
    output o_sb_info,
    output o_src_id,
    output o_grant_init,
    output o_grant_partner,
    output o_done_init,
    output o_done_partner,
    output o_timeout
  );

  // Requester / sideband side
  modport master (
    output i_en,
    output i_req_valid_init,
    output i_req_msg_init,
    output i_req_info_init,
    output i_req_valid_partner,
    output i_req_msg_partner,
    output i_req_info_partner,
    output i_sb_busy,
    input  o_sb_valid,
    input  o_sb_msg,
    input  o_sb_info,
    input  o_src_id,
    input  o_grant_init,
    input  o_grant_partner,
    input  o_done_init,
    input  o_done_partner,
    input  o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/mbinit_sb_tx_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : mbinit_sb_tx_arbiter
// Purpose  : Round-robin sharing of the sideband TX request path between
//            the MBINIT initiator and partner engines.
// Revision : 1.0
// =====================================================================
module mbinit_sb_tx_arbiter #(
  parameter int MSG_W       = 4,
  parameter int INFO_W      = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic             CLK,
  input  wire logic             rst_n,
  mbinit_sb_tx_arbiter_if.slave sb
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_FREE = 3'd3,
    COOLDOWN  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [CNT_W-1:0]  ack_cnt_q;
  logic [CNT_W-1:0]  ack_cnt_nxt;
  logic              rr_ptr_q;
  logic              rr_ptr_nxt;
  logic              busy_q;

  logic              owner_nxt;
  logic [MSG_W-1:0]  msg_nxt;
  logic [INFO_W-1:0] info_nxt;
  logic              granted_nxt;
  logic              done_init_nxt;
  logic              done_partner_nxt;
  logic              timeout_nxt;
  logic              busy_fell;

  logic              sb_valid_q;
  logic [MSG_W-1:0]  sb_msg_q;
  logic [INFO_W-1:0] sb_info_q;
  logic              src_id_q;
  logic              grant_init_q;
  logic              grant_partner_q;
  logic              done_init_q;
  logic              done_partner_q;
  logic              timeout_q;

  assign busy_fell = busy_q & ~sb.i_sb_busy;

  // Owner, message and info live only in the output registers: they hold
  // while granted and are cleared otherwise, so they double as the latch.
  always_comb begin
    state_nxt        = state_q;
    ack_cnt_nxt      = '0;
    rr_ptr_nxt       = rr_ptr_q;
    owner_nxt        = src_id_q;
    msg_nxt          = sb_msg_q;
    info_nxt         = sb_info_q;
    done_init_nxt    = 1'b0;
    done_partner_nxt = 1'b0;
    timeout_nxt      = 1'b0;

    if (!sb.i_en) begin
      state_nxt  = IDLE;
      rr_ptr_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!sb.i_sb_busy && (sb.i_req_valid_init || sb.i_req_valid_partner)) begin
            state_nxt = LAUNCH;
            if (sb.i_req_valid_init && sb.i_req_valid_partner) begin
              owner_nxt  = rr_ptr_q;
              rr_ptr_nxt = ~rr_ptr_q;
            end else begin
              owner_nxt  = sb.i_req_valid_partner;
            end
            msg_nxt  = owner_nxt ? sb.i_req_msg_partner  : sb.i_req_msg_init;
            info_nxt = owner_nxt ? sb.i_req_info_partner : sb.i_req_info_init;
          end
        end
        LAUNCH: begin
          state_nxt = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (sb.i_sb_busy) begin
            state_nxt = WAIT_FREE;
          end else if (ack_cnt_q == CNT_LAST) begin
            state_nxt   = COOLDOWN;
            timeout_nxt = 1'b1;
          end
        end
        WAIT_FREE: begin
          if (busy_fell) begin
            state_nxt        = COOLDOWN;
            done_init_nxt    = ~src_id_q;
            done_partner_nxt = src_id_q;
          end
        end
        COOLDOWN: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Counts cycles since launch: 1 on the first WAIT_ACK cycle.
    if (state_nxt == WAIT_ACK) begin
      ack_cnt_nxt = ack_cnt_q + CNT_W'(1);
    end
  end

  assign granted_nxt = (state_nxt == LAUNCH) || (state_nxt == WAIT_ACK) ||
                       (state_nxt == WAIT_FREE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      rr_ptr_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ack_cnt_q <= ack_cnt_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      busy_q    <= sb.i_sb_busy;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_q      <= 1'b0;
      sb_msg_q        <= '0;
      sb_info_q       <= '0;
      src_id_q        <= 1'b0;
      grant_init_q    <= 1'b0;
      grant_partner_q <= 1'b0;
      done_init_q     <= 1'b0;
      done_partner_q  <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      sb_valid_q      <= (state_nxt == LAUNCH);
      sb_msg_q        <= granted_nxt ? msg_nxt  : '0;
      sb_info_q       <= granted_nxt ? info_nxt : '0;
      src_id_q        <= granted_nxt & owner_nxt;
      grant_init_q    <= granted_nxt & ~owner_nxt;
      grant_partner_q <= granted_nxt & owner_nxt;
      done_init_q     <= done_init_nxt;
      done_partner_q  <= done_partner_nxt;
      timeout_q       <= timeout_nxt;
    end
  end

  assign sb.o_sb_valid      = sb_valid_q;
  assign sb.o_sb_msg        = sb_msg_q;
  assign sb.o_sb_info       = sb_info_q;
  assign sb.o_src_id        = src_id_q;
  assign sb.o_grant_init    = grant_init_q;
  assign sb.o_grant_partner = grant_partner_q;
  assign sb.o_done_init     = done_init_q;
  assign sb.o_done_partner  = done_partner_q;
  assign sb.o_timeout       = timeout_q;

  a_single_owner : assert property (@(posedge CLK) disable iff (!rst_n)
    !(grant_init_q && grant_partner_q));
  a_launch_pulse : assert property (@(posedge CLK) disable iff (!rst_n)
    sb_valid_q |=> !sb_valid_q);
  a_end_exclusive : assert property (@(posedge CLK) disable iff (!rst_n)
    !((done_init_q || done_partner_q) && timeout_q));

endmodule
`default_nettype wire
